amux_scan_ctrl: RTL and testbench

Digital scan sequencer that drives the 2-bit select of the 4-input analog multiplexer and orchestrates ADC conversions of the selected input. It steps through an enabled subset of the four channels and waits a programmable settling time after each select change. It then handshakes one conversion with the ADC and stores one result register per channel for the CPU-side register bank. It sits in the 1.8 V digital domain, directly upstream of the mux select and alongside the ADC control interface.

---
 rtl/amux_pkg.sv | 51 +++++
 rtl/amux_scan_ctrl_if.sv | 33 +++
 rtl/amux_cycle_timer.sv | 31 +++
 rtl/amux_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_amux_scan_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/amux_pkg.sv
// rtl/amux_pkg.sv - shared types and channel helpers for the analog mux scan sequencer
// Contents:
//   NUM_CH, CH_W           channel count and select width
//   amux_state_e           sequencer states
//   chan_sel_t             {found, ch} result of a channel search
//   next_enabled_channel   lowest enabled channel strictly above cur
//   first_enabled_channel  lowest enabled channel in a mask
package amux_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CONVERT,
    WAIT,
    NEXT
  } amux_state_e;

  typedef struct packed {
    logic            found;
    logic [CH_W-1:0] ch;
  } chan_sel_t;

  // Scans downward so the lowest qualifying channel is the last one written.
  function automatic chan_sel_t next_enabled_channel(input logic [NUM_CH-1:0] mask,
                                                     input logic [CH_W-1:0]   cur);
    chan_sel_t r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        r.found = 1'b1;
        r.ch    = CH_W'(i);
      end
    end
    return r;
  endfunction

  function automatic logic [CH_W-1:0] first_enabled_channel(input logic [NUM_CH-1:0] mask);
    logic [CH_W-1:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        r = CH_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/amux_scan_ctrl_if.sv
// rtl/amux_scan_ctrl_if.sv - mux select and ADC conversion handshake bundle
// Signals:
//   sel        mux select driven by the sequencer
//   adc_start  one-cycle conversion request
//   adc_done   one-cycle conversion-complete pulse from the ADC
//   adc_data   conversion result, valid with adc_done
// Modports: master = sequencer side, slave = mux/ADC side.
interface amux_scan_ctrl_if
  import amux_pkg::*;
#(
  parameter int ADC_W = 10
);

  logic [CH_W-1:0]  sel;
  logic             adc_start;
  logic             adc_done;
  logic [ADC_W-1:0] adc_data;

  modport master (
    output sel,
    output adc_start,
    input  adc_done,
    input  adc_data
  );

  modport slave (
    input  sel,
    input  adc_start,
    output adc_done,
    output adc_data
  );

endinterface

// File: rtl/amux_cycle_timer.sv
// rtl/amux_cycle_timer.sv - loadable down-counter with zero flag
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load       load load_val this cycle (has priority over counting)
//   load_val   value to load
//   zero       count has reached zero; counting stops there
module amux_cycle_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/amux_scan_ctrl.sv
// rtl/amux_scan_ctrl.sv - analog mux scan sequencer with per-channel ADC result registers
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   start                single-cycle scan request, ignored while busy
//   continuous           repeat passes; examined at the end of every pass
//   chan_mask            enabled channels, latched at start
//   adc                  mux select / ADC handshake (master side)
//   result0..result3     last converted value per channel
//   valid, timeout_err   per-channel written / abandoned flags, cleared at start
//   busy, pass_done      scan in progress, one-cycle end-of-pass pulse
module amux_scan_ctrl
  import amux_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADC_W          = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] chan_mask,
  amux_scan_ctrl_if.master  adc,
  output logic [ADC_W-1:0]  result0,
  output logic [ADC_W-1:0]  result1,
  output logic [ADC_W-1:0]  result2,
  output logic [ADC_W-1:0]  result3,
  output logic [NUM_CH-1:0] valid,
  output logic [NUM_CH-1:0] timeout_err,
  output logic              busy,
  output logic              pass_done
);

  localparam int TW = 16;
  // Settle: loaded on entry to SETTLE, SETTLE lasts SETTLE_CYCLES clocks.
  localparam logic [TW-1:0] SETTLE_LOAD  = TW'(SETTLE_CYCLES - 1);
  // Timeout: loaded while in CONVERT, so NEXT is reached TIMEOUT_CYCLES
  // clocks after the adc_start cycle.
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 2);

  amux_state_e      state;
  logic [CH_W-1:0]  ch;
  logic [NUM_CH-1:0] mask_q;
  logic             adc_start_q;
  logic [ADC_W-1:0] res_q [NUM_CH];

  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_zero;
  chan_sel_t        nxt;

  assign nxt = next_enabled_channel(mask_q, ch);

  // Keep the timer preloaded in every state that can precede a counted one.
  always_comb begin
    tmr_load = (state == IDLE) || (state == NEXT) || (state == CONVERT);
    tmr_val  = (state == CONVERT) ? TIMEOUT_LOAD : SETTLE_LOAD;
  end

  amux_cycle_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .rst      (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ch          <= '0;
      mask_q      <= '0;
      adc_start_q <= 1'b0;
      busy        <= 1'b0;
      pass_done   <= 1'b0;
      valid       <= '0;
      timeout_err <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        res_q[i] <= '0;
      end
    end else begin
      adc_start_q <= 1'b0;
      pass_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (chan_mask != '0)) begin
            mask_q      <= chan_mask;
            valid       <= '0;
            timeout_err <= '0;
            busy        <= 1'b1;
            ch          <= first_enabled_channel(chan_mask);
            state       <= SETTLE;
          end
        end
        SETTLE: begin
          if (tmr_zero) begin
            adc_start_q <= 1'b1;
            state       <= CONVERT;
          end
        end
        CONVERT: begin
          state <= WAIT;
        end
        WAIT: begin
          // A done arriving on the timeout cycle still counts as a result.
          if (adc.adc_done) begin
            res_q[ch] <= adc.adc_data;
            valid[ch] <= 1'b1;
            pass_done <= !nxt.found;
            state     <= NEXT;
          end else if (tmr_zero) begin
            timeout_err[ch] <= 1'b1;
            pass_done       <= !nxt.found;
            state           <= NEXT;
          end
        end
        NEXT: begin
          if (nxt.found) begin
            ch    <= nxt.ch;
            state <= SETTLE;
          end else if (continuous) begin
            ch    <= first_enabled_channel(mask_q);
            state <= SETTLE;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign adc.sel       = ch;
  assign adc.adc_start = adc_start_q;

  assign result0 = res_q[0];
  assign result1 = res_q[1];
  assign result2 = res_q[2];
  assign result3 = res_q[3];

endmodule

// File: tb/tb_amux_scan_ctrl.sv
// tb/tb_amux_scan_ctrl.sv - self-checking bench for amux_scan_ctrl
module tb_amux_scan_ctrl;

  localparam int S  = 16;
  localparam int TO = 1024;
  localparam int W  = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         continuous;
  logic [3:0]   chan_mask;
  logic [W-1:0] result0, result1, result2, result3;
  logic [3:0]   valid, timeout_err;
  logic         busy, pass_done;

  amux_scan_ctrl_if #(.ADC_W(W)) adc ();

  amux_scan_ctrl #(
    .SETTLE_CYCLES  (S),
    .TIMEOUT_CYCLES (TO),
    .ADC_W          (W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .continuous  (continuous),
    .chan_mask   (chan_mask),
    .adc         (adc),
    .result0     (result0),
    .result1     (result1),
    .result2     (result2),
    .result3     (result3),
    .valid       (valid),
    .timeout_err (timeout_err),
    .busy        (busy),
    .pass_done   (pass_done)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ADC behaviour and observed events
  logic [3:0]   dead;
  int           rsp_delay;
  logic [W-1:0] rsp_data [4];
  bit           rsp_pend = 1'b0;
  int           rsp_cnt  = 0;
  logic [1:0]   rsp_ch   = 2'b00;
  logic         prev_busy = 1'b0;

  int           st_cyc [$];
  logic [1:0]   st_sel [$];
  int           pd_cyc [$];
  int           fall_cyc [$];

  logic [W-1:0] exp_res [4];

  function automatic logic [W-1:0] res_of(input int c);
    case (c)
      0:       return result0;
      1:       return result1;
      2:       return result2;
      default: return result3;
    endcase
  endfunction

  always @(negedge clk) begin
    adc.adc_done = 1'b0;
    if (rsp_pend) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        rsp_pend = 1'b0;
        if (!dead[rsp_ch]) begin
          adc.adc_done = 1'b1;
          adc.adc_data = rsp_data[rsp_ch];
          if (busy) check("sel_hold", 32'(adc.sel), 32'(rsp_ch));
        end
      end
    end
    if (adc.adc_start === 1'b1) begin
      st_cyc.push_back(cyc);
      st_sel.push_back(adc.sel);
      rsp_pend  = 1'b1;
      rsp_cnt   = rsp_delay;
      rsp_ch    = adc.sel;
    end
    if (pass_done === 1'b1) pd_cyc.push_back(cyc);
    if (prev_busy && (busy === 1'b0)) fall_cyc.push_back(cyc);
    prev_busy = (busy === 1'b1);
  end

  task automatic clear_events();
    st_cyc.delete();
    st_sel.delete();
    pd_cyc.delete();
    fall_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) exp_res[c] = '0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((busy === 1'b1) && (n < limit)) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(busy), 32'(0));
  endtask

  // One single-mode pass. Expected sequence and timing come from the scan
  // rules: enabled channels ascending, first adc_start S clocks after the
  // select change, the next select one clock after NEXT, and NEXT reached
  // one clock after done or TO clocks after adc_start on timeout.
  task automatic run_scan(input logic [3:0] mask, input logic [3:0] dd, input int dly);
    int t0, exp_t;
    int en [$];
    dead      = dd;
    rsp_delay = dly;
    clear_events();
    for (int c = 0; c < 4; c++) if (mask[c]) en.push_back(c);
    @(negedge clk);
    chan_mask  = mask;
    continuous = 1'b0;
    start      = 1'b1;
    t0         = cyc + 1;
    @(negedge clk);
    start     = 1'b0;
    chan_mask = 4'($urandom);
    check("busy_rise", 32'(busy), 32'(mask != 4'b0));
    wait_idle(8000);
    repeat (3) @(negedge clk);
    check("n_starts", st_cyc.size(), en.size());
    exp_t = t0 + S;
    for (int i = 0; i < en.size(); i++) begin
      if (i > 0) exp_t += (dd[en[i-1]] ? TO : dly + 1) + 1 + S;
      if (i < st_cyc.size()) begin
        check("sel_seq", 32'(st_sel[i]), en[i]);
        check("start_cyc", st_cyc[i], exp_t);
      end
    end
    if (en.size() > 0) begin
      exp_t += dd[en[en.size()-1]] ? TO : dly + 1;
      check("n_pass", pd_cyc.size(), 1);
      if (pd_cyc.size() > 0) check("pass_cyc", pd_cyc[0], exp_t);
      check("n_busy_fall", fall_cyc.size(), 1);
      if (fall_cyc.size() > 0) check("busy_fall_cyc", fall_cyc[0], exp_t + 1);
      for (int c = 0; c < 4; c++) if (mask[c] && !dd[c]) exp_res[c] = rsp_data[c];
    end else begin
      check("n_pass", pd_cyc.size(), 0);
    end
    for (int c = 0; c < 4; c++) check($sformatf("result%0d", c), 32'(res_of(c)), 32'(exp_res[c]));
  endtask

  typedef struct {
    logic [3:0] mask;
    logic [3:0] dead;
    int         dly;
    logic [3:0] exp_valid;
    logic [3:0] exp_terr;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] mv, mt, m, dd;
    int n, dly;

    tbl[0] = '{4'b1111, 4'b0000, 5, 4'b1111, 4'b0000};
    tbl[1] = '{4'b0101, 4'b0000, 5, 4'b0101, 4'b0000};
    tbl[2] = '{4'b0100, 4'b0100, 5, 4'b0000, 4'b0100};
    tbl[3] = '{4'b0000, 4'b0000, 5, 4'b0000, 4'b0000};
    tbl[4] = '{4'b1000, 4'b0000, 1, 4'b1000, 4'b0000};
    tbl[5] = '{4'b1011, 4'b0010, 8, 4'b1001, 4'b0010};

    reset      = 1'b1;
    start      = 1'b0;
    continuous = 1'b0;
    chan_mask  = 4'b0;
    dead       = 4'b0;
    rsp_delay  = 5;
    for (int c = 0; c < 4; c++) begin
      rsp_data[c] = W'(10'h100 + c);
      exp_res[c]  = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_sel", 32'(adc.sel), 32'(0));
    check("rst_adc_start", 32'(adc.adc_start), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_pass_done", 32'(pass_done), 32'(0));
    check("rst_valid", 32'(valid), 32'(0));
    check("rst_terr", 32'(timeout_err), 32'(0));
    check("rst_result0", 32'(result0), 32'(0));
    reset = 1'b0;

    // table-driven single scans, each from reset
    for (int k = 0; k < 6; k++) begin
      do_reset();
      for (int c = 0; c < 4; c++) rsp_data[c] = W'(10'h100 + c);
      run_scan(tbl[k].mask, tbl[k].dead, tbl[k].dly);
      check("tbl_valid", 32'(valid), 32'(tbl[k].exp_valid));
      check("tbl_terr", 32'(timeout_err), 32'(tbl[k].exp_terr));
    end

    // continuous mode: three passes over 0011, stop requested mid pass 3
    do_reset();
    dead      = 4'b0;
    rsp_delay = 3;
    clear_events();
    @(negedge clk);
    chan_mask  = 4'b0011;
    continuous = 1'b1;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while ((pd_cyc.size() < 2) && (n < 2000)) begin
      @(negedge clk);
      n++;
    end
    check("cont_two_passes", pd_cyc.size(), 2);
    chan_mask = 4'b1111;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while ((st_cyc.size() < 5) && (n < 500)) begin
      @(negedge clk);
      n++;
    end
    continuous = 1'b0;
    wait_idle(2000);
    repeat (3) @(negedge clk);
    check("cont_n_pass", pd_cyc.size(), 3);
    check("cont_n_starts", st_cyc.size(), 6);
    if (st_cyc.size() == 6) begin
      check("cont_sel4", 32'(st_sel[4]), 32'(0));
      check("cont_sel5", 32'(st_sel[5]), 32'(1));
      check("cont_restart_cyc", st_cyc[2], pd_cyc[0] + 1 + S);
    end
    check("cont_valid", 32'(valid), 32'(4'b0011));
    check("cont_terr", 32'(timeout_err), 32'(0));
    check("cont_result2", 32'(result2), 32'(0));

    // reset while waiting on the ADC
    do_reset();
    for (int c = 0; c < 4; c++) rsp_data[c] = W'(10'h100 + c);
    run_scan(4'b1111, 4'b0000, 6);
    clear_events();
    @(negedge clk);
    chan_mask = 4'b1111;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while ((st_cyc.size() < 1) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_sel", 32'(adc.sel), 32'(0));
    check("arst_adc_start", 32'(adc.adc_start), 32'(0));
    check("arst_busy", 32'(busy), 32'(0));
    check("arst_result3", 32'(result3), 32'(0));
    check("arst_result0", 32'(result0), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) exp_res[c] = '0;
    repeat (10) @(negedge clk);
    check("arst_late_done_result0", 32'(result0), 32'(0));
    check("arst_late_done_valid", 32'(valid), 32'(0));
    check("arst_no_new_start", st_cyc.size(), 1);

    // randomized single scans against the pass model
    mv = valid;
    mt = timeout_err;
    for (int r = 0; r < 10; r++) begin
      m   = 4'($urandom_range(1, 15));
      dd  = ($urandom_range(0, 3) == 0) ? (m & (4'b0001 << $urandom_range(0, 3))) : 4'b0000;
      dly = $urandom_range(1, 8);
      for (int c = 0; c < 4; c++) rsp_data[c] = W'($urandom_range(0, 1023));
      run_scan(m, dd, dly);
      mv = m & ~dd;
      mt = m & dd;
      check("rnd_valid", 32'(valid), 32'(mv));
      check("rnd_terr", 32'(timeout_err), 32'(mt));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
